pipe_hazard_ctl: RTL and testbench

PIPE_HAZARD_CTL -- requirements
Module: pipe_hazard_ctl

---
 rtl/pipe_hazard_ctl_pkg.sv | 27 ++
 rtl/pipe_fwd_sel.sv | 24 ++
 rtl/pipe_hazard_ctl.sv | 119 +++++++++++
 tb/tb_pipe_hazard_ctl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctl_pkg.sv
// Shared pipeline definitions: forward-select encodings, the pipeline slot
// record, and the helper that decides whether a slot produces a source reg.
package pipe_hazard_ctl_pkg;

  // Operand select encodings driven on fwda/fwdb.
  localparam logic [1:0] FWD_RF    = 2'b00;  // register file
  localparam logic [1:0] FWD_E_ALU = 2'b01;  // E-stage ALU result
  localparam logic [1:0] FWD_M_ALU = 2'b10;  // M-stage ALU result
  localparam logic [1:0] FWD_M_MEM = 2'b11;  // M-stage memory data

  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

  // What the hazard logic needs to know about an in-flight instruction.
  typedef struct packed {
    logic [4:0] rn;
    logic       wreg;
    logic       m2reg;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{rn: 5'd0, wreg: 1'b0, m2reg: 1'b0};

  // True when the slot writes src; r0 is hard-wired and never produced.
  function automatic logic slot_writes(input slot_t s, input logic [4:0] src);
    return s.wreg && (s.rn != 5'd0) && (s.rn == src);
  endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// One operand's forward select: the youngest producer (E) wins, and an
// E-stage load is skipped because its data does not exist yet.
module pipe_fwd_sel
  import pipe_hazard_ctl_pkg::*;
(
  input  logic [4:0] src,
  input  slot_t      e_slot,
  input  slot_t      m_slot,
  output logic [1:0] sel
);

  // Priority: E ALU result, then M load data, then M ALU result, else regfile.
  always_comb begin
    sel = FWD_RF;
    if (slot_writes(e_slot, src) && !e_slot.m2reg) begin
      sel = FWD_E_ALU;
    end else if (slot_writes(m_slot, src) && m_slot.m2reg) begin
      sel = FWD_M_MEM;
    end else if (slot_writes(m_slot, src)) begin
      sel = FWD_M_ALU;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Decode-stage hazard controller: detects load-use hazards, inserts a
// one-cycle bubble, squashes on flush, selects forwarding paths and counts
// load-use stall cycles. E/M slots shadow the D/E and E/M pipeline registers.
module pipe_hazard_ctl
  import pipe_hazard_ctl_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [4:0]  d_rn,
  input  logic        d_use_rs,
  input  logic        d_use_rt,
  input  logic        d_wreg,
  input  logic        d_m2reg,
  input  logic        d_wmem,
  input  logic        flush,
  output logic        dwreg,
  output logic        dm2reg,
  output logic        dwmem,
  output logic [1:0]  fwda,
  output logic [1:0]  fwdb,
  output logic        wpcir,
  output logic [15:0] stall_cnt
);

  slot_t       e_slot_reg    = SLOT_EMPTY;
  slot_t       m_slot_reg    = SLOT_EMPTY;
  logic [15:0] stall_cnt_reg = 16'd0;

  slot_t       e_slot_next;
  logic [15:0] stall_cnt_next;
  logic        load_use;
  logic        stall;

  logic [1:0][4:0] src_regs;
  logic [1:0][1:0] fwd_sel;

  // A load in E whose destination is read by the decode instruction.
  always_comb begin
    load_use = e_slot_reg.wreg && e_slot_reg.m2reg && (e_slot_reg.rn != 5'd0) &&
               ((d_use_rs && (e_slot_reg.rn == d_rs)) ||
                (d_use_rt && (e_slot_reg.rn == d_rt)));
  end

  // Control gating: flush kills the instruction without holding the PC;
  // a load-use hazard kills it and holds PC/IF-ID so it is reissued.
  always_comb begin
    dwreg  = d_wreg;
    dm2reg = d_m2reg;
    dwmem  = d_wmem;
    wpcir  = 1'b1;
    stall  = 1'b0;
    if (flush) begin
      dwreg  = 1'b0;
      dm2reg = 1'b0;
      dwmem  = 1'b0;
    end else if (load_use) begin
      dwreg  = 1'b0;
      dm2reg = 1'b0;
      dwmem  = 1'b0;
      wpcir  = 1'b0;
      stall  = 1'b1;
    end
  end

  // The E slot captures what actually enters D/E, i.e. the gated controls.
  always_comb begin
    e_slot_next = '{rn: d_rn, wreg: dwreg, m2reg: dm2reg};
  end

  // Saturating stall counter next value.
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (stall && (stall_cnt_reg != STALL_CNT_MAX)) begin
      stall_cnt_next = stall_cnt_reg + 16'd1;
    end
  end

  // Slot shift register, cleared immediately by reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      e_slot_reg <= SLOT_EMPTY;
      m_slot_reg <= SLOT_EMPTY;
    end else begin
      e_slot_reg <= e_slot_next;
      m_slot_reg <= e_slot_reg;
    end
  end

  // Stall counter register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_reg <= 16'd0;
    end else begin
      stall_cnt_reg <= stall_cnt_next;
    end
  end

  assign src_regs[0] = d_rs;
  assign src_regs[1] = d_rt;

  // Identical select logic for both operands; index 0 is rs, 1 is rt.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      pipe_fwd_sel u_fwd_sel (
        .src    (src_regs[gi]),
        .e_slot (e_slot_reg),
        .m_slot (m_slot_reg),
        .sel    (fwd_sel[gi])
      );
    end
  endgenerate

  assign fwda      = fwd_sel[0];
  assign fwdb      = fwd_sel[1];
  assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Bench for pipe_hazard_ctl: table of per-cycle decode inputs with expected
// outputs, pushed to a scoreboard on drive and checked before the next edge,
// followed by hand-written saturation and mid-stall reset sequences.
module tb_pipe_hazard_ctl;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [4:0]  d_rs = '0, d_rt = '0, d_rn = '0;
  logic        d_use_rs = 1'b0, d_use_rt = 1'b0;
  logic        d_wreg = 1'b0, d_m2reg = 1'b0, d_wmem = 1'b0, flush = 1'b0;
  logic        dwreg, dm2reg, dwmem, wpcir;
  logic [1:0]  fwda, fwdb;
  logic [15:0] stall_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic [4:0]  rs, rt, rn;
    logic        use_rs, use_rt, wreg, m2reg, wmem, flush;
    logic [23:0] exp;  // {dwreg,dm2reg,dwmem,fwda,fwdb,wpcir,stall_cnt}
  } vec_t;

  vec_t        tbl [19];
  logic [23:0] sb_q [$];

  pipe_hazard_ctl dut (
    .clock     (clock),
    .resetn    (resetn),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_rn      (d_rn),
    .d_use_rs  (d_use_rs),
    .d_use_rt  (d_use_rt),
    .d_wreg    (d_wreg),
    .d_m2reg   (d_m2reg),
    .d_wmem    (d_wmem),
    .flush     (flush),
    .dwreg     (dwreg),
    .dm2reg    (dm2reg),
    .dwmem     (dwmem),
    .fwda      (fwda),
    .fwdb      (fwdb),
    .wpcir     (wpcir),
    .stall_cnt (stall_cnt)
  );

  always #5 clock = ~clock;

  function automatic logic [23:0] ex(input int w, input int m, input int wm, input int fa,
                                     input int fb, input int pc, input int cnt);
    return {w[0], m[0], wm[0], fa[1:0], fb[1:0], pc[0], cnt[15:0]};
  endfunction

  function automatic vec_t mk(input int rs, input int rt, input int rn, input int urs,
                              input int urt, input int w, input int m, input int wm,
                              input int fl, input int ew, input int em, input int ewm,
                              input int fa, input int fb, input int pc, input int cnt);
    vec_t v;
    v.rs = rs[4:0]; v.rt = rt[4:0]; v.rn = rn[4:0];
    v.use_rs = urs[0]; v.use_rt = urt[0];
    v.wreg = w[0]; v.m2reg = m[0]; v.wmem = wm[0]; v.flush = fl[0];
    v.exp = ex(ew, em, ewm, fa, fb, pc, cnt);
    return v;
  endfunction

  function automatic logic [23:0] observed();
    return {dwreg, dm2reg, dwmem, fwda, fwdb, wpcir, stall_cnt};
  endfunction

  task automatic check(input string tag, input logic [23:0] act, input logic [23:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
      $display("ok   %-14s outputs=%06h", tag, act);
    end else begin
      $display("FAIL %-14s actual=%06h required=%06h", tag, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    d_rs = v.rs; d_rt = v.rt; d_rn = v.rn;
    d_use_rs = v.use_rs; d_use_rt = v.use_rt;
    d_wreg = v.wreg; d_m2reg = v.m2reg; d_wmem = v.wmem; flush = v.flush;
  endtask

  // Drive now, push expectation, then compare shortly before the rising edge.
  task automatic apply_now(input vec_t v, input string tag);
    logic [23:0] e;
    drive(v);
    sb_q.push_back(v.exp);
    #2;
    e = sb_q.pop_front();
    check(tag, observed(), e);
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clock);
    apply_now(v, tag);
  endtask

  initial begin
    //            rs rt rn urs urt w m wm fl | dw dm dwm fa fb pc cnt
    tbl[0]  = mk( 1, 0, 5, 1, 0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 1, 0);  // lw r5
    tbl[1]  = mk( 5, 1, 6, 1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);  // add r6,r5: stall
    tbl[2]  = mk( 5, 1, 6, 1, 1, 1, 0, 0, 0,  1, 0, 0, 3, 0, 1, 1);  // reissue: M mem
    tbl[3]  = mk( 1, 2, 3, 1, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 1, 1);  // add r3
    tbl[4]  = mk( 3, 3, 4, 1, 1, 1, 0, 0, 0,  1, 0, 0, 1, 1, 1, 1);  // sub r4,r3,r3
    tbl[5]  = mk( 3, 0, 8, 1, 1, 1, 0, 0, 0,  1, 0, 0, 2, 0, 1, 1);  // r3 from M alu
    tbl[6]  = mk( 1, 1, 7, 1, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 1, 1);  // add r7
    tbl[7]  = mk( 2, 2, 7, 1, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 1, 1);  // add r7
    tbl[8]  = mk( 7, 9,10, 1, 1, 1, 0, 0, 0,  1, 0, 0, 1, 0, 1, 1);  // E beats M
    tbl[9]  = mk( 1, 0, 0, 1, 0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 1, 1);  // lw r0
    tbl[10] = mk( 0, 0,11, 1, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 1, 1);  // read r0: no stall
    tbl[11] = mk( 0, 0,12, 1, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0, 1, 1);  // r0 load in M
    tbl[12] = mk( 1, 0, 9, 1, 0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 1, 1);  // lw r9
    tbl[13] = mk(12, 9,13, 0, 1, 1, 0, 1, 1,  0, 0, 0, 2, 0, 1, 1);  // hazard+flush
    tbl[14] = mk( 2, 9,14, 1, 0, 1, 1, 0, 0,  1, 1, 0, 0, 3, 1, 1);  // fwd ignores use
    tbl[15] = mk(14,14,15, 0, 0, 0, 0, 1, 0,  0, 0, 1, 0, 0, 1, 1);  // no use: no stall
    tbl[16] = mk( 1, 0,20, 1, 0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 1, 1);  // lw r20
    tbl[17] = mk( 1,20, 0, 1, 1, 0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1);  // sw r20: stall via rt
    tbl[18] = mk( 1,20, 0, 1, 1, 0, 0, 1, 0,  0, 0, 1, 0, 3, 1, 2);  // reissue

    // Reset held: slots empty, controls pass through, no stall.
    drive(mk(3, 3, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    #12;
    check("reset_hold", observed(), ex(1, 1, 1, 0, 0, 1, 0));
    @(negedge clock);
    resetn = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 19; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Saturation: preload the counter just below the limit, then two stalls.
    apply(mk(1, 0, 5, 1, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 1, 2), "sat_lw1");
    @(negedge clock);
    force dut.stall_cnt_reg = 16'hFFFE;
    #1;
    release dut.stall_cnt_reg;
    apply_now(mk(5, 1, 6, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFE), "sat_stall1");
    apply(mk(5, 1, 6, 1, 1, 1, 0, 0, 0, 1, 0, 0, 3, 0, 1, 16'hFFFF), "sat_hit");
    apply(mk(1, 0, 5, 1, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 1, 16'hFFFF), "sat_lw2");
    apply(mk(5, 1, 6, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF), "sat_stall2");
    apply(mk(5, 1, 6, 1, 1, 1, 0, 0, 0, 1, 0, 0, 3, 0, 1, 16'hFFFF), "sat_hold");

    // Reset in the middle of a stall cycle.
    apply(mk(1, 2, 5, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 16'hFFFF), "rst_add");
    apply(mk(1, 0, 6, 1, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 1, 16'hFFFF), "rst_lw");
    apply(mk(6, 5, 7, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 16'hFFFF), "rst_stall");
    resetn = 1'b0;
    #1;
    check("rst_async", observed(), ex(1, 0, 0, 0, 0, 1, 0));
    @(negedge clock);
    resetn = 1'b1;
    apply_now(mk(6, 5, 7, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0), "rst_first");
    apply(mk(7, 0, 8, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0), "rst_resume");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
